idt_issue_scheduler: RTL and testbench
======================================

// Module: idt_issue_scheduler
// PURPOSE
//  Consumer of the instruction dependency table (IDT) ready vector: picks
//  dependency-free buffer entries, offers one per cycle to the execute unit
//  over a valid/ready handshake, and tracks in-flight entries.
//  On completion it frees the slot and broadcasts a one-hot wake column,
//  which the IDT uses to clear that dependency in every other row.
//  Sits between the IDT and the execute/writeback stage.
// PARAMETERS
//  bs  16           buffer entries; power of two, >= 2
//  IW  $clog2(bs)   index width (derived, not overridden)
// PORTS
//  clk             in   1     rising-edge clock
//  rst_n           in   1     asynchronous, active-low reset
//  ready_index     in   bs    IDT rows with zero outstanding dependencies
//  alloc_valid     in   1     new instruction written into slot alloc_index
//  alloc_index     in   IW    slot being allocated
//  issue_valid     out  1     offer valid
//  issue_index     out  IW    offered slot
//  issue_ready     in   1     execute unit accepts the offer
//  complete_valid  in   1     execute finished slot complete_index
//  complete_index  in   IW    completing slot
//  wake_valid      out  1     one-cycle pulse, wake_mask valid
//  wake_mask       out  bs    one-hot column of the completed slot
//  inflight_count  out  IW+1  slots issued and not yet completed
//  protocol_err    out  1     sticky error flag
// BEHAVIOUR
//  - Reset: all outputs 0; occupied, issued, rr_ptr cleared; state IDLE.
//    A mid-operation reset drops any pending offer immediately.
//  - occupied[i] is set by alloc and cleared by a legal complete.
//    issued[i] is set on handshake and cleared by a legal complete.
//  - eligible = ready_index & occupied & ~issued, excluding the slot currently offered.
//  - Pick: first eligible slot at or above rr_ptr, wrapping modulo bs.
//  - FSM IDLE: if eligible != 0, register the pick into issue_index; the next cycle has
//    issue_valid=1 and state OFFER. One-cycle select-to-offer latency.
//  - FSM OFFER: issue_index and issue_valid are held stable until issue_ready.
//    On handshake (issue_valid & issue_ready):
//    - set issued[idx]; rr_ptr <= idx+1 (wraps).
//    - If another eligible slot exists, load it and stay in OFFER, giving
//      back-to-back issue at 1 per cycle; otherwise go to IDLE.
//  - The offer is not withdrawn if ready_index drops for the offered slot.
//  - Legal complete (slot issued): clear occupied and issued; the next cycle gives
//    wake_valid=1 and wake_mask=1<<complete_index, for exactly one cycle.
//  - Illegal complete (slot not issued): ignored, no wake, protocol_err<=1.
//  - Alloc to an occupied slot: the slot is reinitialised (issued=0) and protocol_err<=1.
//    Alloc to the slot currently offered: the offer is held and protocol_err<=1.
//  - Same-cycle alloc and legal complete on the same index: the complete applies first,
//    then the alloc. The result is occupied=1, issued=0, and the wake is still emitted.
//  - inflight_count: +1 on handshake, -1 on legal complete, unchanged when both occur.
//    It never exceeds bs.
//  - protocol_err is cleared only by reset.
// STRUCTURE
//  - Shared package idt_pkg: bs default, IW, FSM state encoding (IDLE, OFFER).
//  - Sub-module idt_rr_pick: combinational round-robin find-first
//    (inputs req[bs] and ptr[IW]; outputs gnt_valid and gnt_idx[IW]).
//  - Top level: occupied/issued vectors, FSM, offer register, wake register, counter.
// TESTING
//  1. Reset, alloc slot 3, ready_index=0x0008 -> issue_valid=1, issue_index=3
//     two cycles after alloc.
//  2. Slots 1, 5, 9 eligible, rr_ptr=6, issue_ready=1 held -> issues 9, 1, 5 on
//     consecutive cycles; inflight_count=3.
//  3. Offer slot 2 with issue_ready=0 for 4 cycles -> issue_index stays 2 and
//     issue_valid stays 1 throughout.
//  4. Complete slot 9 -> next cycle wake_valid=1, wake_mask=0x0200; slot 9 no
//     longer eligible; inflight_count decremented.
//  5. Complete of never-issued slot 4 -> no wake, protocol_err=1 and stays 1.
//  6. Same-cycle handshake on slot 1 and complete of slot 5 -> inflight_count
//     unchanged; rst_n low mid-offer -> issue_valid=0 asynchronously.

Source files
------------

// File: rtl/idt_pkg.sv
// Shared definitions for the IDT issue scheduler: default buffer size,
// derived index width and the issue FSM state encoding.
package idt_pkg;

    localparam int BS_DEFAULT = 16;
    localparam int IW_DEFAULT = $clog2(BS_DEFAULT);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } sched_state_e;

endpackage

// File: rtl/idt_rr_pick.sv
// Combinational round-robin find-first: grants the first requesting slot
// at or above ptr, wrapping modulo bs.
module idt_rr_pick
    import idt_pkg::*;
#(
    parameter int bs = BS_DEFAULT,
    localparam int IW = $clog2(bs)
) (
    input  logic [bs-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = bs - 1; k >= 0; k--) begin
            cand = ptr + IW'(k);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/idt_issue_scheduler.sv
// Issue scheduler behind the IDT: offers dependency-free slots to execute,
// tracks in-flight slots and broadcasts a wake column on completion.
module idt_issue_scheduler
    import idt_pkg::*;
#(
    parameter int bs = BS_DEFAULT,
    localparam int IW = $clog2(bs)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [bs-1:0] ready_index,
    input  logic          alloc_valid,
    input  logic [IW-1:0] alloc_index,
    output logic          issue_valid,
    output logic [IW-1:0] issue_index,
    input  logic          issue_ready,
    input  logic          complete_valid,
    input  logic [IW-1:0] complete_index,
    output logic          wake_valid,
    output logic [bs-1:0] wake_mask,
    output logic [IW:0]   inflight_count,
    output logic          protocol_err,
    output logic          state_dbg
);

    sched_state_e  state_q, state_d;
    logic [bs-1:0] occupied_q, occupied_d;
    logic [bs-1:0] issued_q, issued_d;
    logic [bs-1:0] offer_mask, eligible;
    logic [IW-1:0] rr_ptr_q, pick_ptr;
    logic [IW-1:0] gnt_idx, issue_index_d;
    logic          gnt_valid, issue_valid_d;
    logic          handshake, legal_complete, alloc_err, err_set;

    // Handshake: an offer (issue_valid/issue_index) is held unchanged until
    // the cycle where issue_valid & issue_ready; that cycle transfers it.
    assign handshake      = issue_valid & issue_ready;
    assign legal_complete = complete_valid & issued_q[complete_index];
    assign offer_mask     = issue_valid ? (bs'(1) << issue_index) : '0;
    assign eligible       = ready_index & occupied_q & ~issued_q & ~offer_mask;
    assign pick_ptr       = handshake ? issue_index + IW'(1) : rr_ptr_q;
    assign state_dbg      = (state_q == OFFER);

    assign alloc_err = alloc_valid &
        ((occupied_q[alloc_index] & ~(legal_complete & (complete_index == alloc_index))) |
         (issue_valid & (issue_index == alloc_index)));
    assign err_set = (complete_valid & ~legal_complete) | alloc_err;

    idt_rr_pick #(.bs(bs)) u_pick (
        .req       (eligible),
        .ptr       (pick_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        state_d       = state_q;
        issue_valid_d = issue_valid;
        issue_index_d = issue_index;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d       = OFFER;
                    issue_valid_d = 1'b1;
                    issue_index_d = gnt_idx;
                end
            end
            OFFER: begin
                if (handshake) begin
                    if (gnt_valid) begin
                        issue_index_d = gnt_idx;
                    end else begin
                        state_d       = IDLE;
                        issue_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d       = IDLE;
                issue_valid_d = 1'b0;
            end
        endcase
    end

    // Complete clears first, alloc reinitialises, handshake marks issued last.
    always_comb begin
        occupied_d = occupied_q;
        issued_d   = issued_q;
        if (legal_complete) begin
            occupied_d[complete_index] = 1'b0;
            issued_d[complete_index]   = 1'b0;
        end
        if (alloc_valid) begin
            occupied_d[alloc_index] = 1'b1;
            issued_d[alloc_index]   = 1'b0;
        end
        if (handshake) begin
            issued_d[issue_index] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_valid <= 1'b0;
            issue_index <= '0;
            occupied_q  <= '0;
            issued_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            issue_valid <= issue_valid_d;
            issue_index <= issue_index_d;
            occupied_q  <= occupied_d;
            issued_q    <= issued_d;
            if (handshake) begin
                rr_ptr_q <= issue_index + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wake_valid     <= 1'b0;
            wake_mask      <= '0;
            inflight_count <= '0;
            protocol_err   <= 1'b0;
        end else begin
            wake_valid <= legal_complete;
            wake_mask  <= legal_complete ? (bs'(1) << complete_index) : '0;
            if (handshake && !legal_complete) begin
                inflight_count <= inflight_count + (IW+1)'(1);
            end else if (!handshake && legal_complete) begin
                inflight_count <= inflight_count - (IW+1)'(1);
            end
            if (err_set) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_idt_issue_scheduler.sv
// Bench for idt_issue_scheduler: directed scenarios plus randomized traffic,
// each cycle compared against a slot-array reference model.
module tb_idt_issue_scheduler;

    localparam int BS = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BS-1:0] ready_index;
    logic          alloc_valid;
    logic [IW-1:0] alloc_index;
    logic          issue_valid;
    logic [IW-1:0] issue_index;
    logic          issue_ready;
    logic          complete_valid;
    logic [IW-1:0] complete_index;
    logic          wake_valid;
    logic [BS-1:0] wake_mask;
    logic [IW:0]   inflight_count;
    logic          protocol_err;
    logic          state_dbg;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [BS-1:0] m_occ, m_iss, m_wm;
    logic          m_ov, m_wv, m_err;
    int            m_oi, m_ptr, m_cnt;

    logic [IW-1:0] hs_log[$];
    logic [IW-1:0] exp_q[$];

    always #5 clk = ~clk;

    idt_issue_scheduler #(.bs(BS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ready_index    (ready_index),
        .alloc_valid    (alloc_valid),
        .alloc_index    (alloc_index),
        .issue_valid    (issue_valid),
        .issue_index    (issue_index),
        .issue_ready    (issue_ready),
        .complete_valid (complete_valid),
        .complete_index (complete_index),
        .wake_valid     (wake_valid),
        .wake_mask      (wake_mask),
        .inflight_count (inflight_count),
        .protocol_err   (protocol_err),
        .state_dbg      (state_dbg)
    );

    function automatic int pick(logic [BS-1:0] elig, int ptr);
        for (int k = 0; k < BS; k++) begin
            if (elig[(ptr + k) % BS]) return (ptr + k) % BS;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_occ = '0; m_iss = '0; m_wm = '0;
        m_ov = 1'b0; m_wv = 1'b0; m_err = 1'b0;
        m_oi = 0; m_ptr = 0; m_cnt = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        logic [BS-1:0] elig;
        bit hs, legal;
        int ci, ai, oi, p;
        ci = int'(complete_index);
        ai = int'(alloc_index);
        oi = m_oi;
        elig = ready_index & m_occ & ~m_iss;
        if (m_ov) elig[oi] = 1'b0;
        hs = m_ov && issue_ready;
        legal = complete_valid && m_iss[ci];
        if (complete_valid && !legal) m_err = 1'b1;
        if (alloc_valid && ((m_occ[ai] && !(legal && ci == ai)) || (m_ov && oi == ai))) m_err = 1'b1;
        m_wv = legal;
        m_wm = legal ? (16'h0001 << ci) : 16'h0000;
        if (legal) begin m_occ[ci] = 1'b0; m_iss[ci] = 1'b0; end
        if (alloc_valid) begin m_occ[ai] = 1'b1; m_iss[ai] = 1'b0; end
        if (hs) m_iss[oi] = 1'b1;
        m_cnt = m_cnt + int'(hs) - int'(legal);
        if (!m_ov) begin
            p = pick(elig, m_ptr);
            if (p >= 0) begin m_ov = 1'b1; m_oi = p; end
        end else if (hs) begin
            m_ptr = (oi + 1) % BS;
            p = pick(elig, m_ptr);
            if (p >= 0) m_oi = p;
            else m_ov = 1'b0;
        end
    endtask

    // One clock: update model, log DUT handshake, sample #1 after the edge.
    task automatic step();
        model_step();
        if (issue_valid && issue_ready) hs_log.push_back(issue_index);
        @(posedge clk);
        #1;
        checks++;
        if (issue_valid !== m_ov) begin
            errors++;
            $display("FAIL issue_valid: got %b expected %b at %0t", issue_valid, m_ov, $time);
        end
        if (m_ov) begin
            checks++;
            if (issue_index !== IW'(m_oi)) begin
                errors++;
                $display("FAIL issue_index: got %0d expected %0d at %0t", issue_index, m_oi, $time);
            end
        end
        checks++;
        if (wake_valid !== m_wv || wake_mask !== m_wm) begin
            errors++;
            $display("FAIL wake: got %b/%h expected %b/%h at %0t", wake_valid, wake_mask, m_wv, m_wm, $time);
        end
        checks++;
        if (inflight_count !== (IW+1)'(m_cnt)) begin
            errors++;
            $display("FAIL inflight_count: got %0d expected %0d at %0t", inflight_count, m_cnt, $time);
        end
        checks++;
        if (protocol_err !== m_err) begin
            errors++;
            $display("FAIL protocol_err: got %b expected %b at %0t", protocol_err, m_err, $time);
        end
        checks++;
        if (state_dbg !== m_ov) begin
            errors++;
            $display("FAIL state_dbg: got %b expected %b at %0t", state_dbg, m_ov, $time);
        end
    endtask

    task automatic idle_inputs();
        ready_index = '0; alloc_valid = 1'b0; alloc_index = '0;
        issue_ready = 1'b0; complete_valid = 1'b0; complete_index = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        hs_log.delete();
    endtask

    task automatic alloc_one(input int idx);
        alloc_valid = 1'b1;
        alloc_index = IW'(idx);
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (issue_valid !== 1'b0 || issue_index !== '0 || wake_valid !== 1'b0 || wake_mask !== '0 ||
            inflight_count !== '0 || protocol_err !== 1'b0 || state_dbg !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b i=%0d w=%b m=%h c=%0d e=%b s=%b expected all zero",
                     issue_valid, issue_index, wake_valid, wake_mask, inflight_count, protocol_err, state_dbg);
        end
    endtask

    task automatic test_first_issue();
        do_reset();
        ready_index = 16'h0008;
        alloc_one(3);
        checks++;
        if (issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_issue_early: got %b expected 0", issue_valid);
        end
        step();
        checks++;
        if (issue_valid !== 1'b1 || issue_index !== 4'd3) begin
            errors++;
            $display("FAIL first_issue: got %b/%0d expected 1/3", issue_valid, issue_index);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        ready_index = 16'h0020;
        issue_ready = 1'b1;
        alloc_one(5);
        repeat (3) step();
        issue_ready = 1'b0;
        complete_valid = 1'b1; complete_index = 4'd5;
        step();
        complete_valid = 1'b0;
        ready_index = '0;
        alloc_one(1);
        alloc_one(5);
        alloc_one(9);
        hs_log.delete();
        exp_q = '{4'd9, 4'd1, 4'd5};
        ready_index = 16'h0222;
        issue_ready = 1'b1;
        repeat (6) step();
        issue_ready = 1'b0;
        checks++;
        if (hs_log.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rr_count: got %0d issues expected %0d", hs_log.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (hs_log[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got %0d expected %0d", i, hs_log[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (inflight_count !== 5'd3) begin
            errors++;
            $display("FAIL rr_inflight: got %0d expected 3", inflight_count);
        end
    endtask

    task automatic test_complete_wake();
        complete_valid = 1'b1; complete_index = 4'd9;
        step();
        complete_valid = 1'b0;
        checks++;
        if (wake_valid !== 1'b1 || wake_mask !== 16'h0200 || inflight_count !== 5'd2) begin
            errors++;
            $display("FAIL wake_9: got %b/%h/%0d expected 1/0200/2", wake_valid, wake_mask, inflight_count);
        end
        step();
        checks++;
        if (wake_valid !== 1'b0 || issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL wake_9_after: got wake=%b offer=%b expected 0/0", wake_valid, issue_valid);
        end
    endtask

    task automatic test_illegal_complete();
        complete_valid = 1'b1; complete_index = 4'd4;
        step();
        complete_valid = 1'b0;
        checks++;
        if (wake_valid !== 1'b0 || protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_complete: got wake=%b err=%b expected 0/1", wake_valid, protocol_err);
        end
        repeat (3) step();
        checks++;
        if (protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b expected 1", protocol_err);
        end
    endtask

    task automatic test_hold_offer();
        do_reset();
        ready_index = 16'h0004;
        alloc_one(2);
        step();
        for (int i = 0; i < 4; i++) begin
            if (i >= 2) ready_index = '0;
            step();
            checks++;
            if (issue_valid !== 1'b1 || issue_index !== 4'd2) begin
                errors++;
                $display("FAIL hold_offer[%0d]: got %b/%0d expected 1/2", i, issue_valid, issue_index);
            end
        end
    endtask

    task automatic test_same_cycle_and_reset();
        do_reset();
        ready_index = 16'h0020;
        issue_ready = 1'b1;
        alloc_one(5);
        repeat (2) step();
        issue_ready = 1'b0;
        ready_index = 16'h0022;
        alloc_one(1);
        step();
        issue_ready = 1'b1;
        complete_valid = 1'b1; complete_index = 4'd5;
        step();
        issue_ready = 1'b0; complete_valid = 1'b0;
        checks++;
        if (inflight_count !== 5'd1 || wake_mask !== 16'h0020) begin
            errors++;
            $display("FAIL same_cycle: got cnt=%0d mask=%h expected 1/0020", inflight_count, wake_mask);
        end
        ready_index = 16'h0080;
        alloc_one(7);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (issue_valid !== 1'b0 || inflight_count !== '0) begin
            errors++;
            $display("FAIL async_reset: got offer=%b cnt=%0d expected 0/0", issue_valid, inflight_count);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        int n;
        int cand[$];
        do_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            ready_index = BS'($urandom) | BS'($urandom);
            issue_ready = ($urandom_range(0, 9) < 7);
            alloc_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                cand.delete();
                for (int i = 0; i < BS; i++) if (!m_occ[i]) cand.push_back(i);
                if (cand.size() > 0 && $urandom_range(0, 19) != 0) begin
                    n = cand[$urandom_range(0, cand.size() - 1)];
                end else begin
                    n = $urandom_range(0, BS - 1);
                end
                alloc_valid = 1'b1;
                alloc_index = IW'(n);
            end
            complete_valid = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                cand.delete();
                for (int i = 0; i < BS; i++) if (m_iss[i]) cand.push_back(i);
                if (cand.size() > 0 && $urandom_range(0, 29) != 0) begin
                    complete_valid = 1'b1;
                    complete_index = IW'(cand[$urandom_range(0, cand.size() - 1)]);
                end else if ($urandom_range(0, 9) == 0) begin
                    complete_valid = 1'b1;
                    complete_index = IW'($urandom_range(0, BS - 1));
                end
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_first_issue();
        test_round_robin();
        test_complete_wake();
        test_illegal_complete();
        test_hold_offer();
        test_same_cycle_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
